// File: rtl/m92_pkg.sv
// Shared m92 definitions: save-memory ioctl index and the nvram bridge state encoding.
package m92_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } nvram_state_t;

  localparam logic [7:0] NVRAM_IOCTL_INDEX = 8'hFF;

endpackage

// File: rtl/nvram_ioctl_port.sv
// Bridges the data_io ioctl channel to the 16-bit save memory: word reads with a
// one-word cache on upload, byte-enabled writes on download, and a dirty flag.
module nvram_ioctl_port
  import m92_pkg::*;
#(
  parameter int         ADDR_W = 13,
  parameter logic [7:0] INDEX  = NVRAM_IOCTL_INDEX
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic [ADDR_W-2:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_q,
  output logic              mem_wr,
  output logic [15:0]       mem_d,
  output logic [1:0]        mem_be,
  input  logic              game_wr,
  output logic              dirty,
  output logic              busy
);

  nvram_state_t      state_q, state_d;
  logic [7:0]        din_q, din_d;
  logic [ADDR_W-2:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [15:0]       mem_d_q, mem_d_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic              busy_q, busy_d;
  logic              dirty_q, dirty_d;
  logic              up_sel_q;
  logic [15:0]       cache_q, cache_d;
  logic [ADDR_W-2:0] cache_word_q, cache_word_d;
  logic              cache_vld_q, cache_vld_d;
  logic [ADDR_W-2:0] rd_word_q, rd_word_d;
  logic              rd_byte_q, rd_byte_d;

  logic              up_sel_s, dn_sel_s, up_go_s, in_range_s, wr_req_s, hit_s;
  logic [ADDR_W-2:0] addr_word_s;

  // Download owns the port when both directions are selected, so a read and a
  // write can never be requested on the same edge.
  assign up_sel_s    = ioctl_upload && (ioctl_index == INDEX);
  assign dn_sel_s    = ioctl_download && (ioctl_index == INDEX);
  assign in_range_s  = ~|ioctl_addr[24:ADDR_W];
  assign addr_word_s = ioctl_addr[ADDR_W-1:1];
  assign wr_req_s    = dn_sel_s && ioctl_wr && in_range_s;
  assign up_go_s     = up_sel_s && !dn_sel_s && !wr_req_s;
  assign hit_s       = cache_vld_q && (addr_word_s == cache_word_q);

  // Next-state, cache and memory-port decode.
  always_comb begin
    state_d      = state_q;
    din_d        = din_q;
    mem_addr_d   = mem_addr_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_d_d      = mem_d_q;
    mem_be_d     = mem_be_q;
    cache_d      = cache_q;
    cache_word_d = cache_word_q;
    cache_vld_d  = cache_vld_q;
    rd_word_d    = rd_word_q;
    rd_byte_d    = rd_byte_q;

    case (state_q)
      IDLE: begin
        if (up_go_s && !in_range_s) begin
          din_d = 8'hFF;
        end else if (up_go_s && hit_s) begin
          din_d = ioctl_addr[0] ? cache_q[15:8] : cache_q[7:0];
        end else if (up_go_s) begin
          state_d    = READ;
          mem_rd_d   = 1'b1;
          mem_addr_d = addr_word_s;
          rd_word_d  = addr_word_s;
          rd_byte_d  = ioctl_addr[0];
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // Completes against the address latched at READ, even if ioctl_addr moved.
        state_d      = IDLE;
        cache_d      = mem_q;
        cache_word_d = rd_word_q;
        cache_vld_d  = 1'b1;
        din_d        = rd_byte_q ? mem_q[15:8] : mem_q[7:0];
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A write after the capture decode so invalidation wins over a same-edge capture.
    if (wr_req_s) begin
      mem_wr_d    = 1'b1;
      mem_addr_d  = addr_word_s;
      mem_d_d     = {ioctl_dout, ioctl_dout};
      mem_be_d    = ioctl_addr[0] ? 2'b10 : 2'b01;
      cache_vld_d = 1'b0;
    end else begin
      mem_wr_d = 1'b0;
    end

    busy_d = (state_d != IDLE);

    if (game_wr) begin
      dirty_d = 1'b1;
    end else if (up_sel_q && !up_sel_s) begin
      dirty_d = 1'b0;
    end else begin
      dirty_d = dirty_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      din_q        <= 8'h00;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_d_q      <= 16'h0000;
      mem_be_q     <= 2'b00;
      busy_q       <= 1'b0;
      dirty_q      <= 1'b0;
      up_sel_q     <= 1'b0;
      cache_q      <= 16'h0000;
      cache_word_q <= '0;
      cache_vld_q  <= 1'b0;
      rd_word_q    <= '0;
      rd_byte_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      din_q        <= din_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_d_q      <= mem_d_d;
      mem_be_q     <= mem_be_d;
      busy_q       <= busy_d;
      dirty_q      <= dirty_d;
      up_sel_q     <= up_sel_s;
      cache_q      <= cache_d;
      cache_word_q <= cache_word_d;
      cache_vld_q  <= cache_vld_d;
      rd_word_q    <= rd_word_d;
      rd_byte_q    <= rd_byte_d;
    end
  end

  assign ioctl_din = din_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_d     = mem_d_q;
  assign mem_be    = mem_be_q;
  assign busy      = busy_q;
  assign dirty     = dirty_q;

endmodule

// File: tb/tb_nvram_ioctl_port.sv
// Directed bench for nvram_ioctl_port: a per-cycle vector table plus hand-written
// sequences for the download bus fields and reset during a read.
module tb_nvram_ioctl_port;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_upload, ioctl_wr, game_wr;
  logic [7:0]  ioctl_index, ioctl_dout, ioctl_din;
  logic [24:0] ioctl_addr;
  logic [11:0] mem_addr;
  logic        mem_rd, mem_wr, dirty, busy;
  logic [15:0] mem_q, mem_d;
  logic [1:0]  mem_be;

  int n_cmp = 0;
  int n_err = 0;

  nvram_ioctl_port dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_q(mem_q),
    .mem_wr(mem_wr), .mem_d(mem_d), .mem_be(mem_be),
    .game_wr(game_wr), .dirty(dirty), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Save-memory model: one-cycle read latency, byte-enabled writes, poison when idle.
  logic [15:0] mem [0:4095];
  initial mem_q = 16'h0000;
  always @(posedge clk_sys) begin
    mem_q <= mem_rd ? mem[mem_addr] : 16'hDEAD;
    if (mem_wr) begin
      if (mem_be[0]) mem[mem_addr][7:0]  <= mem_d[7:0];
      if (mem_be[1]) mem[mem_addr][15:8] <= mem_d[15:8];
    end
  end

  typedef struct {
    logic        up;
    logic        dn;
    logic [7:0]  idx;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        gw;
    logic [7:0]  e_din;
    logic        e_rd;
    logic        e_wr;
    logic        e_busy;
    logic        e_dirty;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic up, input logic dn, input logic [7:0] idx,
                              input logic wr, input logic [24:0] addr, input logic [7:0] dout,
                              input logic gw, input logic [7:0] e_din, input logic e_rd,
                              input logic e_wr, input logic e_busy, input logic e_dirty);
    vec_t v;
    v.up = up; v.dn = dn; v.idx = idx; v.wr = wr; v.addr = addr; v.dout = dout; v.gw = gw;
    v.e_din = e_din; v.e_rd = e_rd; v.e_wr = e_wr; v.e_busy = e_busy; v.e_dirty = e_dirty;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic up, input logic dn, input logic [7:0] idx, input logic wr,
                       input logic [24:0] addr, input logic [7:0] dout, input logic gw);
    ioctl_upload = up; ioctl_download = dn; ioctl_index = idx; ioctl_wr = wr;
    ioctl_addr = addr; ioctl_dout = dout; game_wr = gw;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".din"},   {24'd0, ioctl_din}, 32'd0);
    chk({tag, ".maddr"}, {20'd0, mem_addr},  32'd0);
    chk({tag, ".md"},    {16'd0, mem_d},     32'd0);
    chk({tag, ".mbe"},   {30'd0, mem_be},    32'd0);
    chk({tag, ".ctl"},   {28'd0, mem_rd, mem_wr, busy, dirty}, 32'd0);
  endtask

  initial begin
    for (int w = 0; w < 4096; w++) mem[w] = 16'h0000;
    mem[0] = 16'hBEEF;
    mem[2] = 16'h1234;
    mem[3] = 16'h5678;

    //             up   dn   idx    wr   addr       dout   gw    din    rd   wr   busy dirty
    tbl[0]  = mk(1'b0, 1'b0, 8'hFF, 1'b0, 25'd0,    8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd0,    8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd0,    8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd0,    8'h00, 1'b0, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd1,    8'h00, 1'b0, 8'hBE, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd0,    8'h00, 1'b0, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd8192, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd1,    8'h00, 1'b0, 8'hBE, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 8'hFF, 1'b1, 25'd5,    8'h3C, 1'b0, 8'hBE, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 8'hFF, 1'b0, 25'd5,    8'h3C, 1'b0, 8'hBE, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd4,    8'h00, 1'b0, 8'hBE, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd4,    8'h00, 1'b0, 8'hBE, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd4,    8'h00, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd5,    8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd5,    8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[15] = mk(1'b0, 1'b0, 8'hFF, 1'b0, 25'd5,    8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, 8'hFF, 1'b0, 25'd5,    8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[17] = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd5,    8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[18] = mk(1'b0, 1'b0, 8'hFF, 1'b0, 25'd5,    8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[19] = mk(1'b0, 1'b0, 8'hFF, 1'b0, 25'd5,    8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[20] = mk(1'b1, 1'b0, 8'h00, 1'b0, 25'd0,    8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[21] = mk(1'b1, 1'b1, 8'hFF, 1'b1, 25'd6,    8'hA5, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[22] = mk(1'b1, 1'b1, 8'hFF, 1'b1, 25'd7,    8'h5A, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[23] = mk(1'b1, 1'b1, 8'hFF, 1'b0, 25'd7,    8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[24] = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd7,    8'h00, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[25] = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd7,    8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[26] = mk(1'b1, 1'b0, 8'hFF, 1'b0, 25'd7,    8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[27] = mk(1'b1, 1'b1, 8'hFF, 1'b1, 25'd8192, 8'h77, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[28] = mk(1'b0, 1'b0, 8'hFF, 1'b0, 25'd0,    8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[29] = mk(1'b0, 1'b1, 8'hFF, 1'b1, 25'd0,    8'hEF, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 25'd0, 8'h00, 1'b0);
    tick();
    tick();
    chk_all_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].up, tbl[i].dn, tbl[i].idx, tbl[i].wr, tbl[i].addr, tbl[i].dout, tbl[i].gw);
      tick();
      chk($sformatf("v%0d.din", i),   {24'd0, ioctl_din}, {24'd0, tbl[i].e_din});
      chk($sformatf("v%0d.rd", i),    {31'd0, mem_rd},    {31'd0, tbl[i].e_rd});
      chk($sformatf("v%0d.wr", i),    {31'd0, mem_wr},    {31'd0, tbl[i].e_wr});
      chk($sformatf("v%0d.busy", i),  {31'd0, busy},      {31'd0, tbl[i].e_busy});
      chk($sformatf("v%0d.dirty", i), {31'd0, dirty},     {31'd0, tbl[i].e_dirty});
    end

    // Download bus fields for an odd-address byte.
    drive(1'b0, 1'b1, 8'hFF, 1'b1, 25'd5, 8'h3C, 1'b0);
    tick();
    chk("dl.wr",    {31'd0, mem_wr},   32'd1);
    chk("dl.addr",  {20'd0, mem_addr}, 32'd2);
    chk("dl.d",     {16'd0, mem_d},    32'h3C3C);
    chk("dl.be",    {30'd0, mem_be},   32'd2);
    drive(1'b0, 1'b0, 8'hFF, 1'b0, 25'd5, 8'h3C, 1'b0);
    tick();
    chk("dl.wr_end", {31'd0, mem_wr}, 32'd0);

    // Reset while a read is in flight, then a fresh read of word 0.
    drive(1'b1, 1'b0, 8'hFF, 1'b0, 25'd2, 8'h00, 1'b1);
    tick();
    chk("rst.rd_start", {31'd0, mem_rd},   32'd1);
    chk("rst.rd_addr",  {20'd0, mem_addr}, 32'd1);
    chk("rst.dirty",    {31'd0, dirty},    32'd1);
    game_wr = 1'b0;
    reset_n = 1'b0;
    tick();
    chk_all_zero("rst.mid");
    ioctl_upload = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("rst.idle_rd", {31'd0, mem_rd}, 32'd0);
    drive(1'b1, 1'b0, 8'hFF, 1'b0, 25'd0, 8'h00, 1'b0);
    tick();
    chk("rst.fresh_rd",   {31'd0, mem_rd},   32'd1);
    chk("rst.fresh_addr", {20'd0, mem_addr}, 32'd0);
    tick();
    tick();
    chk("rst.fresh_din",  {24'd0, ioctl_din}, 32'hEF);
    chk("rst.fresh_busy", {31'd0, busy},      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nvram_ioctl_port.md
# nvram_ioctl_port

Bridges the data_io ioctl channel to the game's 16-bit save memory (EEPROM/NVRAM image, index 8'hFF). On upload it is the reader: it fetches words from the save memory and presents bytes on `ioctl_din`. On download it writes restored bytes back with byte enables. It also tracks a dirty flag so the menu save path knows when contents changed. It sits between data_io and the m92 save-memory second port, all on CLK_40M.

## Interface
- `ADDR_W`, default 13: byte address width of the save region (8192 bytes).
- `INDEX`, default 8'hFF: ioctl index that selects this block.
- `clk_sys` in 1: system clock (CLK_40M).
- `reset_n` in 1: asynchronous active-low reset.
- `ioctl_download` in 1: download active.
- `ioctl_upload` in 1: upload active.
- `ioctl_index` in 8: transfer index.
- `ioctl_wr` in 1: download byte strobe, one cycle wide.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: download byte.
- `ioctl_din` out 8: upload byte.
- `mem_addr` out ADDR_W-1: word address.
- `mem_rd` out 1: read strobe, one cycle wide.
- `mem_q` in 16: read data, valid exactly 1 cycle after `mem_rd`.
- `mem_wr` out 1: write strobe, one cycle wide.
- `mem_d` out 16: write data.
- `mem_be` out 2: byte enables, bit0 = low byte.
- `game_wr` in 1: the game core wrote save memory.
- `dirty` out 1: contents changed since the last completed upload.
- `busy` out 1: a read is in flight.

## Operation
- Selection: `up_sel = ioctl_upload && ioctl_index==INDEX`; `dn_sel = ioctl_download && ioctl_index==INDEX`. If both are set, download takes priority and the upload FSM holds in IDLE.
- Byte order is little-endian. Even byte address maps to `mem_q[7:0]`, odd to `[15:8]`.
- In range means `ioctl_addr < 2**ADDR_W`.
- Upload FSM has three states: IDLE, READ, CAPTURE.
  - IDLE → READ when `up_sel` and (the address changed since the last capture, or the cache is invalid).
  - If the new address falls in the cached word (same `addr[ADDR_W-1:1]`, cache valid), no memory read is issued. `ioctl_din` updates from the cache on the next cycle and the FSM stays in IDLE.
  - READ: pulse `mem_rd`, drive `mem_addr = ioctl_addr[ADDR_W-1:1]`, set `busy`, → CAPTURE.
  - CAPTURE: latch `mem_q` into the cache, mark the cache valid, drive `ioctl_din` with the selected byte, clear `busy`, → IDLE.
  - If the address changes while in READ or CAPTURE, the capture completes, then the FSM re-evaluates in IDLE.
- Out-of-range upload address: no read is issued; `ioctl_din` = 8'hFF one cycle after the change.
- Download, on `dn_sel && ioctl_wr` with an in-range address:
  - pulse `mem_wr` the next cycle;
  - `mem_d = {ioctl_dout, ioctl_dout}`;
  - `mem_be = addr[0] ? 2'b10 : 2'b01`;
  - invalidate the cache.
- Download with an out-of-range address: the write is dropped silently.
- Dirty flag:
  - set on `game_wr`;
  - cleared on the falling edge of `up_sel`;
  - if `game_wr` coincides with that edge, set wins.
  - A download does not set `dirty`.

## Timing
- Reset values:
  - `ioctl_din` = 0, `mem_addr` = 0, `mem_d` = 0, `mem_be` = 0;
  - `mem_rd`, `mem_wr`, `busy`, `dirty` = 0;
  - cache invalid, FSM in IDLE.
- Upload miss: address change at cycle N; `mem_rd` at N+1; `ioctl_din` valid at N+3 and held until the next capture.
- Upload cache hit: `ioctl_din` valid at N+1.
- Download: `mem_wr` one cycle after `ioctl_wr`. Back-to-back `ioctl_wr` on consecutive cycles produces back-to-back `mem_wr`.
- `mem_rd` and `mem_wr` are never asserted in the same cycle. If a write is pending, the read is delayed one cycle.
- Asynchronous reset mid-read: the in-flight read is abandoned and its `mem_q` is ignored.

## Structure
- Shared package `m92_pkg`:
  - state enum `nvram_state_t` (IDLE, READ, CAPTURE);
  - constant `NVRAM_IOCTL_INDEX = 8'hFF`.
- Single module; no sub-module is needed.
- The byte-select mux stays inline.

## Test plan
- Reset: assert `reset_n` = 0 mid-READ → all outputs 0 next edge; after release, first upload at addr 0 issues a fresh `mem_rd`.
- Upload miss/hit: `mem_q` = 16'hBEEF for word 0. Addr 0 → `mem_rd` at N+1, `ioctl_din` = 8'hEF at N+3. Addr 1 → no `mem_rd`, `ioctl_din` = 8'hBE at N+1.
- Download: `ioctl_wr` at addr 5 with 8'h3C → next cycle `mem_wr` = 1, `mem_addr` = 2, `mem_d` = 16'h3C3C, `mem_be` = 2'b10. The following upload at addr 4 re-reads memory.
- Range: upload at addr 8192 → `ioctl_din` = 8'hFF and no `mem_rd`. Download at 8192 → no `mem_wr`.
- Dirty: `game_wr` pulse → `dirty` = 1. Complete an upload → `dirty` = 0. `game_wr` on the same cycle as the upload falling edge → `dirty` stays 1.
- Index filter: upload with index 0 → no `mem_rd`. Upload and download both asserted → writes occur, no reads.
